// File: rtl/cc_pkg.sv
// Shared definitions for the sort_rank_seq batch sorter: FSM states,
// opt bit positions and the width of the transformed value.
package cc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SORT,
        ST_OUT
    } state_e;

    // Bit positions inside the opt mode field
    localparam int unsigned OPT_SIGNED = 0;
    localparam int unsigned OPT_DESC   = 1;
    localparam int unsigned OPT_XFORM  = 2;

    // Stored values carry this many guard bits above the entry width
    localparam int unsigned VAL_EXT_BITS = 4;

    function automatic int unsigned val_width(input int unsigned w);
        return w + VAL_EXT_BITS;
    endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Single signed compare-swap cell on {value, id} pairs. Equal values are
// ordered by id, so the lower arrival index always ends up in the lo slot.
module sort_cmp_swap #(
    parameter int unsigned VW = 8,
    parameter int unsigned IW = 3
) (
    input  logic                 desc,
    input  logic signed [VW-1:0] lo_val,
    input  logic        [IW-1:0] lo_id,
    input  logic signed [VW-1:0] hi_val,
    input  logic        [IW-1:0] hi_id,
    output logic signed [VW-1:0] out_lo_val,
    output logic        [IW-1:0] out_lo_id,
    output logic signed [VW-1:0] out_hi_val,
    output logic        [IW-1:0] out_hi_id
);

    logic swap;

    // Decide whether the pair is out of order, then route it
    always_comb begin
        swap = 1'b0;
        if (lo_val == hi_val) begin
            swap = (lo_id > hi_id);
        end else if (desc) begin
            swap = (lo_val < hi_val);
        end else begin
            swap = (lo_val > hi_val);
        end
        out_lo_val = swap ? hi_val : lo_val;
        out_lo_id  = swap ? hi_id  : lo_id;
        out_hi_val = swap ? lo_val : hi_val;
        out_hi_id  = swap ? lo_id  : hi_id;
    end

endmodule

// File: rtl/sort_rank_seq.sv
// Batch sorter: loads N entries, sorts them by odd-even transposition
// (one phase per cycle) and streams out the ranked {id, value} pairs.
// Optional build macro SORT_RANK_SEQ_TRANSFORM_EN enables the
// ext*(a+1)+b transform at load time; without it the extended value is stored.
module sort_rank_seq
    import cc_pkg::*;
#(
    parameter int unsigned N = 7,
    parameter int unsigned W = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [W-1:0]              in_data,
    input  logic [2:0]                opt,
    input  logic [1:0]                a,
    input  logic [2:0]                b,
    output logic                      busy,
    output logic                      out_valid,
    output logic [$clog2(N)-1:0]      out_id,
    output logic [val_width(W)-1:0]   out_val
);

    localparam int unsigned VW = val_width(W);
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned NC = N / 2;

    state_e                state_q, state_d;
    logic [IW-1:0]         cnt_q, cnt_d;
    logic signed [VW-1:0]  val_q [N];
    logic signed [VW-1:0]  val_d [N];
    logic [IW-1:0]         id_q [N];
    logic [IW-1:0]         id_d [N];
    logic                  sgn_q, sgn_d;
    logic                  desc_q, desc_d;
    logic                  out_valid_q, out_valid_d;
    logic [IW-1:0]         out_id_q, out_id_d;
    logic [VW-1:0]         out_val_q, out_val_d;
    logic                  busy_q, busy_d;

`ifdef SORT_RANK_SEQ_TRANSFORM_EN
    logic                  xf_q, xf_d;
    logic [1:0]            gain_q, gain_d;
    logic [2:0]            off_q, off_d;
`else
    logic                  unused_xform;
    assign unused_xform = ^{a, b, opt[OPT_XFORM]};
`endif

    logic                  first;
    logic                  accept;
    logic                  cur_sgn;
    logic signed [VW-1:0]  ext_v;
    logic signed [VW-1:0]  new_val;
    logic                  phase_odd;

    // Sort network: cell inputs, cell outputs, next array after one phase
    logic signed [VW-1:0]  c_lo_v [NC];
    logic signed [VW-1:0]  c_hi_v [NC];
    logic [IW-1:0]         c_lo_i [NC];
    logic [IW-1:0]         c_hi_i [NC];
    logic signed [VW-1:0]  o_lo_v [NC];
    logic signed [VW-1:0]  o_hi_v [NC];
    logic [IW-1:0]         o_lo_i [NC];
    logic [IW-1:0]         o_hi_i [NC];
    logic signed [VW-1:0]  net_v [N];
    logic [IW-1:0]         net_i [N];

    assign phase_odd = cnt_q[0];

    // Cell k sees pair (2k,2k+1) on even phases and (2k+1,2k+2) on odd ones
    for (genvar k = 0; k < NC; k++) begin : g_cell
        if (2 * k + 2 < N) begin : g_both
            assign c_lo_v[k] = phase_odd ? val_q[2*k+1] : val_q[2*k];
            assign c_lo_i[k] = phase_odd ? id_q[2*k+1]  : id_q[2*k];
            assign c_hi_v[k] = phase_odd ? val_q[2*k+2] : val_q[2*k+1];
            assign c_hi_i[k] = phase_odd ? id_q[2*k+2]  : id_q[2*k+1];
        end else begin : g_even
            assign c_lo_v[k] = val_q[2*k];
            assign c_lo_i[k] = id_q[2*k];
            assign c_hi_v[k] = val_q[2*k+1];
            assign c_hi_i[k] = id_q[2*k+1];
        end

        sort_cmp_swap #(.VW(VW), .IW(IW)) u_cs (
            .desc       (desc_q),
            .lo_val     (c_lo_v[k]),
            .lo_id      (c_lo_i[k]),
            .hi_val     (c_hi_v[k]),
            .hi_id      (c_hi_i[k]),
            .out_lo_val (o_lo_v[k]),
            .out_lo_id  (o_lo_i[k]),
            .out_hi_val (o_hi_v[k]),
            .out_hi_id  (o_hi_i[k])
        );
    end

    // Each position picks the cell output that owns it in the current phase
    for (genvar i = 0; i < N; i++) begin : g_pos
        logic signed [VW-1:0] ev_v, od_v;
        logic [IW-1:0]        ev_i, od_i;
        if ((i % 2 == 0) && (i + 1 < N)) begin : g_ev_lo
            assign ev_v = o_lo_v[i/2];
            assign ev_i = o_lo_i[i/2];
        end else if (i % 2 == 1) begin : g_ev_hi
            assign ev_v = o_hi_v[i/2];
            assign ev_i = o_hi_i[i/2];
        end else begin : g_ev_keep
            assign ev_v = val_q[i];
            assign ev_i = id_q[i];
        end
        if ((i % 2 == 1) && (i + 1 < N)) begin : g_od_lo
            assign od_v = o_lo_v[i/2];
            assign od_i = o_lo_i[i/2];
        end else if ((i % 2 == 0) && (i >= 2)) begin : g_od_hi
            assign od_v = o_hi_v[i/2-1];
            assign od_i = o_hi_i[i/2-1];
        end else begin : g_od_keep
            assign od_v = val_q[i];
            assign od_i = id_q[i];
        end
        assign net_v[i] = phase_odd ? od_v : ev_v;
        assign net_i[i] = phase_odd ? od_i : ev_i;
    end

    // Extend and optionally transform the incoming entry
    always_comb begin
        first   = (state_q == ST_IDLE);
        accept  = in_valid && ((state_q == ST_IDLE) || (state_q == ST_LOAD));
        cur_sgn = first ? opt[OPT_SIGNED] : sgn_q;
        ext_v   = cur_sgn ? {{VAL_EXT_BITS{in_data[W-1]}}, in_data}
                          : {{VAL_EXT_BITS{1'b0}}, in_data};
        new_val = ext_v;
`ifdef SORT_RANK_SEQ_TRANSFORM_EN
        begin
            logic       cur_xf;
            logic [1:0] cur_a;
            logic [2:0] cur_b;
            logic [2:0] gain;
            cur_xf = first ? opt[OPT_XFORM] : xf_q;
            cur_a  = first ? a : gain_q;
            cur_b  = first ? b : off_q;
            gain   = {1'b0, cur_a} + 3'd1;
            if (cur_xf) begin
                new_val = ext_v * $signed({{(VW-3){1'b0}}, gain})
                        + $signed({{(VW-3){1'b0}}, cur_b});
            end
        end
`endif
    end

    // Next-state logic for the FSM, storage and registered outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        val_d       = val_q;
        id_d        = id_q;
        sgn_d       = sgn_q;
        desc_d      = desc_q;
`ifdef SORT_RANK_SEQ_TRANSFORM_EN
        xf_d        = xf_q;
        gain_d      = gain_q;
        off_d       = off_q;
`endif
        out_valid_d = 1'b0;
        out_id_d    = '0;
        out_val_d   = '0;
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (accept) begin
                    val_d[cnt_q] = new_val;
                    id_d[cnt_q]  = cnt_q;
                    if (first) begin
                        sgn_d  = opt[OPT_SIGNED];
                        desc_d = opt[OPT_DESC];
`ifdef SORT_RANK_SEQ_TRANSFORM_EN
                        xf_d   = opt[OPT_XFORM];
                        gain_d = a;
                        off_d  = b;
`endif
                    end
                    if (cnt_q == IW'(N - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_SORT;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_SORT: begin
                val_d = net_v;
                id_d  = net_i;
                if (cnt_q == IW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_OUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_OUT: begin
                out_valid_d = 1'b1;
                out_id_d    = id_q[cnt_q];
                out_val_d   = val_q[cnt_q];
                if (cnt_q == IW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == ST_SORT) || (state_d == ST_OUT);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            val_q       <= '{default: '0};
            id_q        <= '{default: '0};
            sgn_q       <= 1'b0;
            desc_q      <= 1'b0;
`ifdef SORT_RANK_SEQ_TRANSFORM_EN
            xf_q        <= 1'b0;
            gain_q      <= '0;
            off_q       <= '0;
`endif
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_val_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            val_q       <= val_d;
            id_q        <= id_d;
            sgn_q       <= sgn_d;
            desc_q      <= desc_d;
`ifdef SORT_RANK_SEQ_TRANSFORM_EN
            xf_q        <= xf_d;
            gain_q      <= gain_d;
            off_q       <= off_d;
`endif
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_val_q   <= out_val_d;
            busy_q      <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_val   = out_val_q;

endmodule

// File: tb/tb_sort_rank_seq.sv
// Directed bench for sort_rank_seq (N=7, W=4): table of batches with
// hand-computed rankings plus reset-in-LOAD and reset-in-OUT sequences.
module tb_sort_rank_seq;

    localparam int N = 7;
    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = '0;
    logic [2:0] opt = '0;
    logic [1:0] a = '0;
    logic [2:0] b = '0;
    logic       busy;
    logic       out_valid;
    logic [2:0] out_id;
    logic [7:0] out_val;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int seq [N] = '{8, 11, 8, 0, 5, 14, 7};

    typedef struct {
        int opt;
        int a;
        int b;
        int gaps;
        int pulse;
        int ids [N];
        int vals [N];
    } vec_t;

    vec_t vecs [5];

    sort_rank_seq #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .opt       (opt),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .out_valid (out_valid),
        .out_id    (out_id),
        .out_val   (out_val)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Feed the fixed sequence; opt/b are scrambled after the first entry
    task automatic feed(input int o, input int ga, input int gb, input int gaps,
                        input int count, output int t_last);
        t_last = 0;
        for (int i = 0; i < count; i++) begin
            if (gaps != 0 && (i == 2 || i == 5)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = 4'(seq[i]);
            opt      = (i == 0) ? 3'(o) : ~3'(o);
            a        = 2'(ga);
            b        = (i == 0) ? 3'(gb) : ~3'(gb);
            @(posedge clk); #1;
            t_last = cyc;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input int v);
        int  t_last;
        int  found;
        int  zero_ok;
        string tag;
        tag = $sformatf("v%0d", v);
        feed(vecs[v].opt, vecs[v].a, vecs[v].b, vecs[v].gaps, N, t_last);
        chk({tag, "_busy_sort"}, int'(busy), 1);
        found = 0;
        zero_ok = 1;
        for (int c = 0; c < 20; c++) begin
            if (vecs[v].pulse != 0 && c == 1) begin
                in_valid = 1'b1;
                in_data  = 4'd15;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (out_valid) begin
                found = 1;
                break;
            end
            if (out_id != 0 || out_val != 0) zero_ok = 0;
        end
        chk({tag, "_latency"}, found != 0 ? cyc - t_last : -1, 8);
        chk({tag, "_zero_before"}, zero_ok, 1);
        if (found != 0) begin
            for (int r = 0; r < N; r++) begin
                chk($sformatf("%s_valid_r%0d", tag, r), int'(out_valid), 1);
                chk($sformatf("%s_id_r%0d", tag, r), int'(out_id), vecs[v].ids[r]);
                chk($sformatf("%s_val_r%0d", tag, r), int'($signed(out_val)), vecs[v].vals[r]);
                @(posedge clk); #1;
            end
        end
        chk({tag, "_valid_end"}, int'(out_valid), 0);
        chk({tag, "_busy_end"}, int'(busy), 0);
        chk({tag, "_zero_end"}, int'(out_id) + int'(out_val), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_last;
        int found;

        vecs[0] = '{opt: 0, a: 0, b: 0, gaps: 0, pulse: 0,
                    ids: '{3, 4, 6, 0, 2, 1, 5}, vals: '{0, 5, 7, 8, 8, 11, 14}};
        vecs[1] = '{opt: 1, a: 0, b: 0, gaps: 0, pulse: 0,
                    ids: '{0, 2, 1, 5, 3, 4, 6}, vals: '{-8, -8, -5, -2, 0, 5, 7}};
        vecs[2] = '{opt: 3, a: 0, b: 0, gaps: 0, pulse: 0,
                    ids: '{6, 4, 3, 5, 1, 0, 2}, vals: '{7, 5, 0, -2, -5, -8, -8}};
`ifdef SORT_RANK_SEQ_TRANSFORM_EN
        vecs[3] = '{opt: 5, a: 2, b: 6, gaps: 0, pulse: 0,
                    ids: '{0, 2, 1, 5, 3, 4, 6}, vals: '{-18, -18, -9, 0, 6, 21, 27}};
`else
        vecs[3] = '{opt: 5, a: 2, b: 6, gaps: 0, pulse: 0,
                    ids: '{0, 2, 1, 5, 3, 4, 6}, vals: '{-8, -8, -5, -2, 0, 5, 7}};
`endif
        vecs[4] = '{opt: 0, a: 0, b: 0, gaps: 1, pulse: 1,
                    ids: '{3, 4, 6, 0, 2, 1, 5}, vals: '{0, 5, 7, 8, 8, 11, 14}};

        // Asynchronous reset with no clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_id", int'(out_id), 0);
        chk("rst_val", int'(out_val), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 5; v++) run_vec(v);

        // Reset in the middle of LOAD discards the partial batch
        feed(1, 0, 0, 0, 3, t_last);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(0);

        // Reset while rank 3 is on the output
        feed(0, 0, 0, 0, N, t_last);
        found = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                found = 1;
                break;
            end
        end
        chk("or_found", found, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("or_rank3_id", int'(out_id), 0);
        chk("or_rank3_val", int'($signed(out_val)), 8);
        rst_n = 1'b0;
        #1;
        chk("or_rst_valid", int'(out_valid), 0);
        chk("or_rst_val", int'(out_val), 0);
        chk("or_rst_id", int'(out_id), 0);
        chk("or_rst_busy", int'(busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("or_idle_valid", int'(out_valid), 0);
        run_vec(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sort_rank_seq.md
SORT_RANK_SEQ -- requirements
Module: sort_rank_seq

Interface
REQ-001 SHALL have parameter N, default 7: number of entries per batch, N >= 2.
REQ-002 SHALL have parameter W, default 4: entry width in bits, W >= 2.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: in_data is valid this cycle.
REQ-006 SHALL have port in_data, input, W: entry value.
REQ-007 SHALL have port opt, input, 3: mode, sampled with the first entry of a batch; bit0 = signed, bit1 = descending, bit2 = transform.
REQ-008 SHALL have port a, input, 2: transform gain; effective multiplier is a+1.
REQ-009 SHALL have port b, input, 3: unsigned transform offset, sampled with the first entry.
REQ-010 SHALL have port busy, output, 1: high in SORT and OUT.
REQ-011 SHALL have port out_valid, output, 1: out_id and out_val are valid.
REQ-012 SHALL have port out_id, output, clog2(N): original arrival index (0-based) of the ranked entry.
REQ-013 SHALL have port out_val, output, W+4: two's-complement transformed value of that entry.

Function
REQ-014 SHALL implement FSM IDLE -> LOAD -> SORT -> OUT -> IDLE.
- IDLE -> LOAD on the first accepted entry.
- LOAD -> SORT after the Nth accept.
- SORT -> OUT after exactly N cycles.
- OUT -> IDLE after N output cycles.
REQ-015 SHALL accept entries only in IDLE/LOAD when in_valid=1; gaps in in_valid during LOAD SHALL be tolerated, and the counter SHALL hold.
REQ-016 SHALL ignore in_valid in SORT and OUT; no entry is stored and no state changes.
REQ-017 SHALL extend each entry at accept: sign-extend if opt[0]=1, else zero-extend, to W+4 bits.
REQ-018 SHALL compute the stored value at accept: ext*(a+1)+b when opt[2]=1, else ext; the result is exact in W+4 bits with no saturation.
REQ-019 SHALL sort in SORT by odd-even transposition, one compare-swap phase per cycle, N phases, all compares signed on W+4 bits.
REQ-020 SHALL order ascending when opt[1]=0 and descending when opt[1]=1; ties SHALL keep the lower arrival index first (stable).
REQ-021 SHALL, if the last accept is at edge T, hold SORT for edges T+1..T+N and assert out_valid for edges T+N+1..T+2N, N consecutive cycles, rank 0 first.
REQ-022 SHALL drive out_id and out_val to 0 whenever out_valid=0.
REQ-023 SHALL accept a new batch's first entry in the cycle after the last out_valid, with no dead cycle beyond the IDLE return.

Reset
REQ-024 SHALL, on rst_n=0, immediately force the state to IDLE, counters to 0, and busy, out_valid, out_id and out_val to 0, regardless of current state.
REQ-025 SHALL discard a partially loaded or sorting batch on reset mid-operation; the first accept after release starts a fresh batch.

Configuration
REQ-026 SHALL, with macro SORT_RANK_SEQ_TRANSFORM_EN defined, implement REQ-018 fully.
REQ-027 SHALL, without SORT_RANK_SEQ_TRANSFORM_EN, ignore opt[2], a and b, store the extended value directly, and keep all other behaviour identical.

Structure
REQ-028 SHALL place the FSM state enum, the opt bit-position constants and the out_val width (W+4) in shared package cc_pkg.
REQ-029 SHALL use one sub-module, sort_cmp_swap: a single signed compare-swap cell carrying {value, id} pairs and a descending flag, with the tie rule of REQ-020; it is instantiated floor(N/2) times.

Verification
All scenarios use N=7, W=4 and the input sequence 8,11,8,0,5,14,7.
REQ-030 SHALL cover opt=0 -> out_id 3,4,6,0,2,1,5 and out_val 0,5,7,8,8,11,14.
REQ-031 SHALL cover opt=1 -> out_id 0,2,1,5,3,4,6 and out_val -8,-8,-5,-2,0,5,7.
REQ-032 SHALL cover opt=3 -> out_id 6,4,3,5,1,0,2 (tie -8: id0 before id2).
REQ-033 SHALL cover opt=5, a=2, b=6, with the macro defined -> out_id 0,2,1,5,3,4,6 and out_val -18,-18,-9,0,6,21,27; without the macro, the same stimulus gives the REQ-031 result.
REQ-034 SHALL cover inputs with two idle in_valid gaps, then a pulse of in_valid during SORT -> output identical to REQ-030, with first out_valid exactly 8 edges after the last accept.
REQ-035 SHALL cover rst_n low for 1 cycle during OUT rank 3 -> outputs 0 immediately, state IDLE; a next full batch then produces a correct result.
